// File: rtl/spi_slave_pkg.sv
// Shared definitions for the APB-programmable SPI slave: register map,
// CTRL/STATUS bit positions, frame state encoding and a bit-order helper.
package spi_slave_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CPOL   = 1;
    localparam int CTRL_CPHA   = 2;
    localparam int CTRL_LSB    = 3;
    localparam int CTRL_RX_IE  = 4;
    localparam int CTRL_ERR_IE = 5;
    localparam int CTRL_W      = 6;

    localparam int STAT_RX_CNT   = 0;
    localparam int STAT_TX_CNT   = 4;
    localparam int STAT_OVERRUN  = 8;
    localparam int STAT_UNDERRUN = 9;
    localparam int STAT_BUSY     = 10;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_LOAD  = 2'd1,
        FSM_SHIFT = 2'd2
    } frame_state_t;

    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_fifo.sv
// Synchronous byte FIFO; a pop in the same cycle frees room for a push into a
// full FIFO, while a push into an empty FIFO is never visible to a same-cycle pop.
module spi_slave_fifo
    import spi_slave_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESETN,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/spi_slave_apb.sv
// SPI slave with APB register window, TX/RX byte FIFOs and a PCLK-domain
// oversampling front end; SPI pins are synchronised and edge-detected here.
module spi_slave_apb
    import spi_slave_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ,
    input  logic        ss_pad_i,
    input  logic        sclk_pad_i,
    input  logic        mosi_pad_i,
    output logic        miso_pad_o,
    output logic        miso_oe_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] ss_pipe_reg;
    logic [SYNC_STAGES-1:0] sclk_pipe_reg;
    logic [SYNC_STAGES-1:0] mosi_pipe_reg;
    logic                   ss_prev_reg;
    logic                   sclk_prev_reg;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic                   sample_edge, shift_edge;

    logic [CTRL_W-1:0]      ctrl_reg;
    logic                   overrun_reg, underrun_reg;
    logic                   pready_reg;
    logic [31:0]            prdata_reg;
    logic [31:0]            rdata_next;
    logic                   irq_reg;

    frame_state_t           state_reg;
    logic [2:0]             bitcnt_reg;
    logic [7:0]             tx_shift_reg;
    logic [7:0]             rx_shift_reg;
    logic                   miso_reg;
    logic                   cpha_act_reg;
    logic                   lsb_act_reg;
    logic                   sample_rising_reg;

    logic                   apb_fire, wr_fire, rd_fire;
    logic                   tx_push, rx_pop, ctrl_wr, status_wr, flush;
    logic                   frame_ok, load_now, last_sample;
    logic [7:0]             rx_byte_next, rx_push_data, tx_load_byte;
    logic                   overrun_set, underrun_set;

    logic [7:0]             tx_head, rx_head;
    logic [CW-1:0]          tx_cnt, rx_cnt;
    logic                   tx_full, tx_empty, rx_full, rx_empty;
    logic                   unused_ok;

    assign unused_ok = ^{PADDR[1:0], PWDATA[31:10]};

    // ---------------- input synchronisers and edge detection ----------------
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ss_pipe_reg   <= '1;
            sclk_pipe_reg <= '0;
            mosi_pipe_reg <= '0;
            ss_prev_reg   <= 1'b1;
            sclk_prev_reg <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                ss_pipe_reg[i]   <= ss_pipe_reg[i-1];
                sclk_pipe_reg[i] <= sclk_pipe_reg[i-1];
                mosi_pipe_reg[i] <= mosi_pipe_reg[i-1];
            end
            ss_pipe_reg[0]   <= ss_pad_i;
            sclk_pipe_reg[0] <= sclk_pad_i;
            mosi_pipe_reg[0] <= mosi_pad_i;
            ss_prev_reg      <= ss_s;
            sclk_prev_reg    <= sclk_s;
        end
    end

    assign ss_s      = ss_pipe_reg[SYNC_STAGES-1];
    assign sclk_s    = sclk_pipe_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe_reg[SYNC_STAGES-1];
    assign ss_fall   = ss_prev_reg & ~ss_s;
    assign ss_rise   = ~ss_prev_reg & ss_s;
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;

    assign sample_edge = sample_rising_reg ? sclk_rise : sclk_fall;
    assign shift_edge  = sample_rising_reg ? sclk_fall : sclk_rise;

    // ---------------- APB decode ----------------
    assign apb_fire  = PSEL & PENABLE & pready_reg;
    assign wr_fire   = apb_fire & PWRITE;
    assign rd_fire   = apb_fire & ~PWRITE;
    assign tx_push   = wr_fire & (PADDR[4:2] == REG_DATA);
    assign rx_pop    = rd_fire & (PADDR[4:2] == REG_DATA);
    assign ctrl_wr   = wr_fire & (PADDR[4:2] == REG_CTRL);
    assign status_wr = wr_fire & (PADDR[4:2] == REG_STATUS);
    // Only the 1->0 transition of en flushes, so TX can be preloaded while disabled.
    assign flush     = ctrl_wr & ctrl_reg[CTRL_EN] & ~PWDATA[CTRL_EN];

    // ---------------- frame datapath strobes ----------------
    assign frame_ok     = ctrl_reg[CTRL_EN] & ~ss_rise;
    assign load_now     = frame_ok & (state_reg == FSM_LOAD);
    assign last_sample  = frame_ok & (state_reg == FSM_SHIFT) & sample_edge & (bitcnt_reg == 3'd7);
    assign rx_byte_next = {rx_shift_reg[6:0], mosi_s};
    assign rx_push_data = lsb_act_reg ? bit_reverse(rx_byte_next) : rx_byte_next;
    assign tx_load_byte = tx_empty ? 8'h00 :
                          (ctrl_reg[CTRL_LSB] ? bit_reverse(tx_head) : tx_head);
    assign overrun_set  = last_sample & rx_full & ~rx_pop;
    assign underrun_set = load_now & tx_empty;

    spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .flush     (flush),
        .push      (tx_push),
        .push_data (PWDATA[7:0]),
        .pop       (load_now),
        .head      (tx_head),
        .count     (tx_cnt),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .flush     (flush),
        .push      (last_sample),
        .push_data (rx_push_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_cnt),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // ---------------- frame FSM ----------------
    // Both shifters run MSB-out/MSB-in; LSB-first mode is handled by reversing
    // the byte on load and on push.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_reg         <= FSM_IDLE;
            bitcnt_reg        <= 3'd0;
            tx_shift_reg      <= 8'h00;
            rx_shift_reg      <= 8'h00;
            miso_reg          <= 1'b0;
            cpha_act_reg      <= 1'b0;
            lsb_act_reg       <= 1'b0;
            sample_rising_reg <= 1'b1;
        end else if (!frame_ok) begin
            state_reg  <= FSM_IDLE;
            bitcnt_reg <= 3'd0;
            miso_reg   <= 1'b0;
        end else begin
            case (state_reg)
                FSM_IDLE: begin
                    miso_reg <= 1'b0;
                    if (ss_fall) begin
                        state_reg <= FSM_LOAD;
                    end
                end
                FSM_LOAD: begin
                    cpha_act_reg      <= ctrl_reg[CTRL_CPHA];
                    lsb_act_reg       <= ctrl_reg[CTRL_LSB];
                    sample_rising_reg <= ~(ctrl_reg[CTRL_CPOL] ^ ctrl_reg[CTRL_CPHA]);
                    bitcnt_reg        <= 3'd0;
                    if (ctrl_reg[CTRL_CPHA]) begin
                        tx_shift_reg <= tx_load_byte;
                    end else begin
                        miso_reg     <= tx_load_byte[7];
                        tx_shift_reg <= {tx_load_byte[6:0], 1'b0};
                    end
                    state_reg <= FSM_SHIFT;
                end
                FSM_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift_reg <= rx_byte_next;
                        bitcnt_reg   <= bitcnt_reg + 3'd1;
                        if (bitcnt_reg == 3'd7) begin
                            state_reg <= FSM_LOAD;
                        end
                    end else if (shift_edge && (cpha_act_reg || bitcnt_reg != 3'd0)) begin
                        // With cpha=0 the first bit went out at LOAD, so the
                        // trailing edge of the previous byte must not shift.
                        miso_reg     <= tx_shift_reg[7];
                        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                    end
                end
                default: begin
                    state_reg <= FSM_IDLE;
                end
            endcase
        end
    end

    // ---------------- registers, read mux, interrupt ----------------
    always_comb begin
        rdata_next = 32'h0;
        case (PADDR[4:2])
            REG_DATA: begin
                if (!rx_empty) begin
                    rdata_next[7:0] = rx_head;
                end
            end
            REG_STATUS: begin
                rdata_next[STAT_RX_CNT +: 3] = 3'(rx_cnt);
                rdata_next[STAT_TX_CNT +: 3] = 3'(tx_cnt);
                rdata_next[STAT_OVERRUN]     = overrun_reg;
                rdata_next[STAT_UNDERRUN]    = underrun_reg;
                rdata_next[STAT_BUSY]        = (state_reg != FSM_IDLE);
            end
            REG_CTRL: begin
                rdata_next[CTRL_W-1:0] = ctrl_reg;
            end
            default: begin
                rdata_next = 32'h0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ctrl_reg     <= '0;
            overrun_reg  <= 1'b0;
            underrun_reg <= 1'b0;
            pready_reg   <= 1'b0;
            prdata_reg   <= 32'h0;
            irq_reg      <= 1'b0;
        end else begin
            pready_reg <= PSEL & PENABLE & ~pready_reg;
            prdata_reg <= rdata_next;
            if (ctrl_wr) begin
                ctrl_reg <= PWDATA[CTRL_W-1:0];
            end
            overrun_reg  <= overrun_set  | (overrun_reg  & ~(status_wr & PWDATA[STAT_OVERRUN]));
            underrun_reg <= underrun_set | (underrun_reg & ~(status_wr & PWDATA[STAT_UNDERRUN]));
            irq_reg      <= (ctrl_reg[CTRL_RX_IE] & (rx_cnt != '0)) |
                            (ctrl_reg[CTRL_ERR_IE] & (overrun_reg | underrun_reg));
        end
    end

    assign PREADY     = pready_reg;
    assign PRDATA     = prdata_reg;
    assign PSLVERR    = 1'b0;
    assign IRQ        = irq_reg;
    assign miso_pad_o = miso_reg;
    assign miso_oe_o  = ctrl_reg[CTRL_EN] & ~ss_s;

endmodule

// File: doc/spi_slave_apb.md
# spi_slave_apb

APB-programmable SPI slave (target) that receives frames driven by an external SPI master on the same SPI bus as the existing APB SPI master. Host software pushes transmit bytes and pops received bytes through a 32-bit APB register window. The block provides 4-deep TX/RX byte FIFOs, an oversampling front end running entirely on PCLK, and a level interrupt. It sits on the peripheral APB bus next to the SPI master and shares its bus conventions: PREADY one cycle after access, PSLVERR tied 0.

## Interface
- FIFO_DEPTH, 4, entries per TX and RX FIFO (power of 2, ≥2)
- SYNC_STAGES, 2, synchronizer flops on each SPI input
- PCLK  in  1  APB clock; sole clock of the block
- PRESETN  in  1  reset PRESETN, asynchronous, active-low; clock PCLK
- PADDR  in  5  byte address; PADDR[4:2] selects register
- PWDATA  in  32  write data
- PRDATA  out  32  registered read data
- PSEL, PENABLE, PWRITE  in  1 each  APB controls
- PREADY  out  1  access completion
- PSLVERR  out  1  constant 0
- IRQ  out  1  registered level interrupt
- ss_pad_i  in  1  slave select, active low, asynchronous
- sclk_pad_i  in  1  serial clock, asynchronous
- mosi_pad_i  in  1  master-out data
- miso_pad_o  out  1  slave-out data
- miso_oe_o  out  1  MISO output enable (pad tristate control)

## Operation
- Registers:
  - 0x00 DATA: read pops RX FIFO head, bits [7:0]; reads 0 when empty, no pop. Write pushes PWDATA[7:0] to TX FIFO; ignored when full.
  - 0x04 STATUS: [2:0] rx_cnt, [6:4] tx_cnt, [8] overrun, [9] underrun, [10] busy (frame in progress). Bits 8/9 are write-1-to-clear.
  - 0x08 CTRL (RW): [0] en, [1] cpol, [2] cpha, [3] lsb, [4] rx_ie, [5] err_ie.
  - Other offsets read 0; writes have no effect.
- APB: access occurs when PSEL&PENABLE. PREADY <= PSEL&PENABLE&~PREADY. Pop, push and W1C take effect only in the PREADY-high cycle, once per access. PRDATA is registered each cycle from the current decode, so it holds the RX head during PREADY.
- Front end: ss/sclk/mosi pass through SYNC_STAGES flops. Edges are detected on the synced sclk.
  - Sample edge is rising when cpol^cpha==0, falling otherwise. The shift edge is the opposite edge.
- Frame FSM states:
  - IDLE: ss_sync high or en=0. On ss_sync falling with en=1, go to LOAD.
  - LOAD (1 cycle): pop TX head into the TX shifter. If TX is empty, load 0x00 and set underrun. bitcnt=0. If cpha=0, drive the first bit immediately. Go to SHIFT.
  - SHIFT, per edge:
    - Sample edge: shift mosi into the RX shifter and increment bitcnt.
    - Shift edge: drive the next TX bit. For cpha=1 the first shift edge drives bit 0.
  - SHIFT, 8th sample edge: push the RX byte. If RX is full, drop the byte and set overrun. Go to LOAD while ss stays low, so back-to-back bytes need no gap.
  - ss_sync rising in any state: go to IDLE, discard the partial byte, no push.
- Bit order: lsb=0 is MSB first on both directions, lsb=1 is LSB first.
- miso_oe_o = en & ~ss_sync. miso_pad_o holds the current TX shifter output bit, or 0 in IDLE.
- Clearing en flushes both FIFOs, forces IDLE, and preserves the error bits. CTRL writes during busy take effect at the next LOAD for cpol/cpha/lsb.
- IRQ <= (rx_ie & rx_cnt≠0) | (err_ie & (overrun|underrun)).

## Timing
- Reset values:
  - PRDATA, PREADY, IRQ, miso_pad_o, miso_oe_o: 0.
  - CTRL = 0; FIFOs empty; error bits 0; FSM IDLE.
- Maximum sclk is PCLK/8. Minimum ss-low-to-first-edge is 4 PCLK.
- Input-to-action latency is SYNC_STAGES+1 PCLK. MISO update latency after the shift edge is ≤ SYNC_STAGES+2 PCLK.
- An RX byte is visible in rx_cnt 1 cycle after the 8th sample edge is detected.
- Simultaneous APB pop and SPI push on a full RX FIFO: the pop happens first and the push succeeds, with no overrun.
- Simultaneous APB push and LOAD pop on an empty TX FIFO: LOAD sees empty, so underrun is set and 0x00 is sent; the pushed byte remains in the FIFO.
- W1C in the same cycle as a new error event: the error bit stays set.

## Structure
- Package spi_slave_pkg: register offsets (DATA/STATUS/CTRL), CTRL and STATUS bit positions, FSM state enum.
- Sub-module spi_slave_fifo: synchronous byte FIFO with push/pop/count/full/empty, instantiated for TX and RX.

## Test plan
- Mode 0 transfer: en=1, TX push 0xA5, master sends 0x3C -> master receives 0xA5, DATA reads 0x3C, rx_cnt goes 1 then 0, and IRQ follows rx_ie.
- Modes 1/2/3 with lsb=1: master sends 0x01 -> DATA reads 0x01, master receives the TX byte bit-reversed relative to MSB mode.
- Underrun: TX FIFO empty, 2-byte burst -> master receives 0x00 0x00, underrun=1. W1C 0x200 clears it.
- Overrun: 5 bytes 0x10..0x14 with no reads -> reads return 0x10..0x13 then 0, overrun=1, IRQ=1 with err_ie.
- Abort: ss rises after 5 bits -> no RX push, busy=0. The next full frame is received correctly.
- Async reset mid-frame: PRESETN low -> all outputs 0, FIFOs empty, CTRL=0 immediately.
